// File: rtl/diagnosis_pkg.sv
// Shared flit types and write-side state encoding for the diagnosis packet buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package diagnosis_pkg;

    localparam int FLIT16_CONTENT_WIDTH = 16;
    localparam int FLIT16_TYPE_WIDTH    = 2;
    localparam int FLIT16_WIDTH         = FLIT16_CONTENT_WIDTH + FLIT16_TYPE_WIDTH;

    typedef enum logic [1:0] {
        PAYLOAD = 2'b00,
        HEADER  = 2'b01,
        LAST    = 2'b10,
        SINGLE  = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_type_t                      ftype;
        logic [FLIT16_CONTENT_WIDTH-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'b00,
        WR_BODY = 2'b01,
        WR_DROP = 2'b10
    } wstate_t;

endpackage

// File: rtl/diagnosis_pkt_buffer_mem.sv
// Flit storage: DEPTH x WIDTH register array, one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller owns all pointer and occupancy logic.
module diagnosis_pkt_buffer_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdat,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents need no reset because only committed entries are ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/diagnosis_pkt_buffer.sv
// Store-and-forward packet buffer: forwards only complete lisnoc16 packets; optional drop counter (DIAGNOSIS_PKTBUF_DROPCNT_EN).
// Latency: a packet's last flit written at edge N is presented on out_valid in cycle N+1; streams 1 flit/clk.
// Backpressure: never stalls the input (in_ready=1 out of reset); packets that do not fit are dropped whole.
module diagnosis_pkt_buffer
    import diagnosis_pkg::*;
#(
    parameter int DEPTH                   = 64,
    parameter int DBG_NOC_DATA_WIDTH      = 16,
    parameter int DBG_NOC_FLIT_TYPE_WIDTH = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_DATA_WIDTH-1:0] in_flit,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    output logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_DATA_WIDTH-1:0] out_flit,
    output logic                                              out_valid,
    input  logic                                              out_ready
`ifdef DIAGNOSIS_PKTBUF_DROPCNT_EN
    ,
    output logic [15:0]                                       drop_count
`endif
);

    localparam int FW = DBG_NOC_FLIT_TYPE_WIDTH + DBG_NOC_DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] commit_ptr, commit_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] pkt_start, pkt_start_nxt;
    logic [PW-1:0] base;
    wstate_t       wstate, wstate_nxt;
    flit_type_t    ftype;
    logic          full_cur;
    logic          full_base;
    logic          restart;
    logic          mem_we;
    logic [1:0]    drop_inc;
    logic [FW-1:0] mem_rdat;

    assign ftype    = flit_type_t'(in_flit[FW-1 -: 2]);
    // Occupancy is judged on pre-read pointers, so a same-cycle read never makes room early.
    assign full_cur = ((wr_ptr - rd_ptr) == DEPTH_P);
    assign full_base = ((base - rd_ptr) == DEPTH_P);

    assign in_ready  = rst;
    assign out_valid = (rd_ptr != commit_ptr);
    assign out_flit  = out_valid ? mem_rdat : '0;

    diagnosis_pkt_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (FW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (base[AW-1:0]),
        .wdat  (in_flit),
        .raddr (rd_ptr[AW-1:0]),
        .rdat  (mem_rdat)
    );

    // Write FSM: body flits extend the open packet; a protocol error rewinds and reprocesses the flit as if idle.
    always_comb begin
        wstate_nxt    = wstate;
        wr_ptr_nxt    = wr_ptr;
        commit_nxt    = commit_ptr;
        pkt_start_nxt = pkt_start;
        mem_we        = 1'b0;
        drop_inc      = 2'd0;
        base          = wr_ptr;
        restart       = 1'b0;
        if (in_valid) begin
            case (wstate)
                WR_BODY: begin
                    case (ftype)
                        PAYLOAD: begin
                            if (!full_cur) begin
                                mem_we     = 1'b1;
                                wr_ptr_nxt = wr_ptr + 1'b1;
                            end else begin
                                wr_ptr_nxt = pkt_start;
                                drop_inc   = 2'd1;
                                wstate_nxt = WR_DROP;
                            end
                        end
                        LAST: begin
                            wstate_nxt = WR_IDLE;
                            if (!full_cur) begin
                                mem_we     = 1'b1;
                                wr_ptr_nxt = wr_ptr + 1'b1;
                                commit_nxt = wr_ptr + 1'b1;
                            end else begin
                                wr_ptr_nxt = pkt_start;
                                drop_inc   = 2'd1;
                            end
                        end
                        default: begin
                            base     = pkt_start;
                            drop_inc = 2'd1;
                            restart  = 1'b1;
                        end
                    endcase
                end
                WR_DROP: begin
                    if (ftype == HEADER) begin
                        restart = 1'b1;
                    end else if (ftype == LAST || ftype == SINGLE) begin
                        wstate_nxt = WR_IDLE;
                    end
                end
                default: restart = 1'b1;
            endcase

            if (restart) begin
                wr_ptr_nxt = base;
                wstate_nxt = WR_IDLE;
                case (ftype)
                    SINGLE: begin
                        if (!full_base) begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = base + 1'b1;
                            commit_nxt = base + 1'b1;
                        end else begin
                            drop_inc = drop_inc + 2'd1;
                        end
                    end
                    HEADER: begin
                        if (!full_base) begin
                            mem_we        = 1'b1;
                            pkt_start_nxt = base;
                            wr_ptr_nxt    = base + 1'b1;
                            wstate_nxt    = WR_BODY;
                        end else begin
                            drop_inc   = drop_inc + 2'd1;
                            wstate_nxt = WR_DROP;
                        end
                    end
                    LAST: drop_inc = drop_inc + 2'd1;
                    default: begin
                        drop_inc   = drop_inc + 2'd1;
                        wstate_nxt = WR_DROP;
                    end
                endcase
            end
        end
    end

    // Pointer and state registers; reset discards stored and partial data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate     <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_start  <= '0;
            rd_ptr     <= '0;
        end else begin
            wstate     <= wstate_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            pkt_start  <= pkt_start_nxt;
            if (out_valid && out_ready) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef DIAGNOSIS_PKTBUF_DROPCNT_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

    // Saturating dropped-packet counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    logic unused_drop_inc;
    assign unused_drop_inc = ^drop_inc;
`endif

endmodule

// File: tb/tb_diagnosis_pkt_buffer.sv
module tb_diagnosis_pkt_buffer;
    import diagnosis_pkg::*;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef DIAGNOSIS_PKTBUF_DROPCNT_EN
    logic [15:0] drop_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: committed flits awaiting output, the open packet, and a mode
    // (0 idle, 1 inside a packet, 2 discarding a packet).
    logic [17:0] exp_q[$];
    logic [17:0] partial[$];
    int          mode = 0;
    int          exp_drops = 0;

    logic        hold = 1'b0;
    logic [17:0] held_flit = '0;

    diagnosis_pkt_buffer #(.DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DIAGNOSIS_PKTBUF_DROPCNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_drops(input string name);
`ifdef DIAGNOSIS_PKTBUF_DROPCNT_EN
        check(name, 32'(drop_count), 32'(exp_drops));
`else
        tests = tests + 0;
`endif
    endtask

    // Packet-level behaviour: occupancy = committed-but-unread + open packet.
    task automatic model(input logic [17:0] f);
        logic [1:0] t;
        bit         full;
        t = f[17:16];
        if (mode == 1 && (t == HEADER || t == SINGLE)) begin
            partial.delete();
            exp_drops++;
            mode = 0;
        end
        full = (exp_q.size() + partial.size()) >= D;
        if (mode == 1) begin
            if (t == PAYLOAD) begin
                if (full) begin partial.delete(); exp_drops++; mode = 2; end
                else partial.push_back(f);
            end else begin
                if (full) begin
                    partial.delete();
                    exp_drops++;
                end else begin
                    partial.push_back(f);
                    foreach (partial[i]) exp_q.push_back(partial[i]);
                    partial.delete();
                end
                mode = 0;
            end
        end else if (mode == 2 && t != HEADER) begin
            if (t == LAST || t == SINGLE) mode = 0;
        end else begin
            mode = 0;
            case (t)
                SINGLE:  if (full) exp_drops++; else exp_q.push_back(f);
                HEADER:  if (full) begin exp_drops++; mode = 2; end
                         else begin partial.push_back(f); mode = 1; end
                LAST:    exp_drops++;
                default: begin exp_drops++; mode = 2; end
            endcase
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] d);
        in_flit  = {t, d};
        in_valid = 1'b1;
        model({t, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        if (len == 1) begin
            send(SINGLE, 16'($urandom));
        end else begin
            send(HEADER, 16'($urandom));
            for (int i = 0; i < len - 2; i++) send(PAYLOAD, 16'($urandom));
            send(LAST, 16'($urandom));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 300) begin
            idle(1);
            guard++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        idle(2);
        check({name, "_no_extra"}, 32'(out_valid), 32'd0);
    endtask

    // Monitor: scoreboard pop on every handshake, plus hold-stability while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_flit", 32'(out_flit), 32'(held_flit));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_flit), 32'h3FFFF + 32'd1);
                end else begin
                    check("out_flit", 32'(out_flit), 32'(exp_q.pop_front()));
                end
            end
            hold      = out_valid && !out_ready;
            held_flit = out_flit;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_flit", 32'(out_flit), 32'd0);
        check_drops("rst_drops");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_run", 32'(in_ready), 32'd1);

        // 1: single flit, visible one clock after commit
        out_ready = 1'b1;
        check("t1_pre_valid", 32'(out_valid), 32'd0);
        send(SINGLE, 16'hABCD);
        check("t1_valid_lat", 32'(out_valid), 32'd1);
        check("t1_flit", 32'(out_flit), 32'h3ABCD);
        idle(2);
        check_drops("t1_drops");

        // 2: 7-flit packet held back until LAST is written
        out_ready = 1'b0;
        send(HEADER, 16'h1000);
        for (int i = 0; i < 5; i++) begin
            check("t2_hidden", 32'(out_valid), 32'd0);
            send(PAYLOAD, 16'(16'h2000 + i));
        end
        check("t2_hidden_last", 32'(out_valid), 32'd0);
        send(LAST, 16'h3000);
        check("t2_visible", 32'(out_valid), 32'd1);
        drain("t2_drain");

        // 3: oversize packet dropped, follow-up delivered
        out_ready = 1'b0;
        send_pkt(10);
        idle(1);
        check("t3_nothing", 32'(out_valid), 32'd0);
        check_drops("t3_drops");
        send_pkt(3);
        drain("t3_drain");

        // 4: 6 committed flits leave no room for a 4-flit packet
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(SINGLE, 16'(16'h4000 + i));
        send_pkt(4);
        check_drops("t4_drops");
        drain("t4_drain");

        // 5: new HEADER mid-packet rewinds the partial packet
        out_ready = 1'b1;
        send(HEADER, 16'h5000);
        send(PAYLOAD, 16'h5001);
        send_pkt(3);
        drain("t5_drain");
        check_drops("t5_drops");

        // 6: reset mid-packet with committed data pending
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(SINGLE, 16'(16'h6000 + i));
        send(HEADER, 16'h6100);
        send(PAYLOAD, 16'h6101);
        rst = 1'b0;
        exp_q.delete();
        partial.delete();
        mode = 0;
        exp_drops = 0;
        idle(1);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check_drops("t6_drops");
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        send_pkt(2);
        drain("t6_after");

        // Randomized traffic with truncated packets, stray flits and variable read pressure
        for (int p = 0; p < 300; p++) begin
            int pct;
            int r;
            pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
            r = $urandom_range(0, 19);
            out_ready = ($urandom_range(0, 99) < pct);
            if (r == 0) begin
                send(($urandom_range(0, 1) == 0) ? LAST : PAYLOAD, 16'($urandom));
            end else if (r < 3) begin
                send(HEADER, 16'($urandom));
                repeat ($urandom_range(0, 3)) begin
                    out_ready = ($urandom_range(0, 99) < pct);
                    send(PAYLOAD, 16'($urandom));
                end
            end else begin
                int len;
                len = $urandom_range(1, 12);
                if (len == 1) begin
                    send(SINGLE, 16'($urandom));
                end else begin
                    send(HEADER, 16'($urandom));
                    for (int i = 0; i < len - 2; i++) begin
                        out_ready = ($urandom_range(0, 99) < pct);
                        send(PAYLOAD, 16'($urandom));
                    end
                    out_ready = ($urandom_range(0, 99) < pct);
                    send(LAST, 16'($urandom));
                end
            end
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 99) < pct);
                idle(1);
            end
        end
        // Close any open packet so the model and DUT end idle
        send(LAST, 16'h0);
        drain("rand_drain");
        check_drops("rand_drops");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
